// File: rtl/battleship_tx_pkg.sv
// Shared types and defaults for the battleship wireless TX serializer.
package battleship_tx_pkg;

  // Frame phases: line idle, start bit, payload bits, stop bit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // 50 MHz system clock at 115200 baud.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned DEFAULT_DATA_W       = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// Bit-period timer: counts clk cycles while enabled and flags the last cycle of each bit.
module tx_baud_gen
  import battleship_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] r_cnt;

  assign bit_tick = enable && (r_cnt == CntMax);

  // Free-running modulo-CLKS_PER_BIT count while a frame is active; clear realigns on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      if (r_cnt == CntMax) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/battleship_tx_serializer.sv
// UART-style frame serializer fed by Nios PIO: start bit, LSB-first payload, one stop bit.
module battleship_tx_serializer
  import battleship_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned BitCntW = cnt_width(DATA_W);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

  tx_state_e          r_state;
  tx_state_e          w_state_nxt;
  logic               r_load_q;
  logic [DATA_W-1:0]  r_shreg;
  logic [DATA_W-1:0]  w_shreg_nxt;
  logic [BitCntW-1:0] r_bit_cnt;
  logic [BitCntW-1:0] w_bit_cnt_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_overrun;
  logic               w_overrun_nxt;
  logic               r_tx;
  logic               w_tx_nxt;
  logic               w_rise;
  logic               w_accept;
  logic               w_bit_tick;

  // load_q resets high so a load already asserted at reset release is not seen as an edge.
  assign w_rise = load & ~r_load_q;

  tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .enable  (r_busy),
    .clear   (w_accept),
    .bit_tick(w_bit_tick)
  );

  // Frame sequencing, payload capture/shift and status flags.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_overrun_nxt = r_overrun;
    w_accept      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_accept      = 1'b1;
          w_shreg_nxt   = data_in;
          w_overrun_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = START;
        end
      end
      START: begin
        if (w_bit_tick) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = DATA;
        end
      end
      DATA: begin
        if (w_bit_tick) begin
          w_shreg_nxt   = r_shreg >> 1;
          w_bit_cnt_nxt = r_bit_cnt + BitCntW'(1);
          if (r_bit_cnt == LastBit) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_bit_tick) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Any edge outside IDLE, including the stop-bit exit cycle, is dropped and flagged.
    if (w_rise && (r_state != IDLE)) begin
      w_overrun_nxt = 1'b1;
    end

    // tx is registered from the next state so the line never glitches on decode.
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shreg_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_load_q  <= 1'b1;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_load_q  <= load;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_overrun <= w_overrun_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_battleship_tx_serializer.sv
// Self-checking bench for battleship_tx_serializer with a queue-based frame model.
module tb_battleship_tx_serializer;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DW    = 8;
  localparam int          FRAME = (DW + 2) * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [DW-1:0] data_in;
  logic          tx;
  logic          busy;
  logic          done;
  logic          overrun;

  always #5 clk = ~clk;

  battleship_tx_serializer #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .data_in(data_in),
    .tx     (tx),
    .busy   (busy),
    .done   (done),
    .overrun(overrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a frame is a queue of per-cycle line levels built at accept time.
  bit   mq[$];
  logic m_busy;
  logic m_tx;
  logic m_done;
  logic m_ovr;
  logic m_prev_load;

  typedef struct {
    logic [DW-1:0] data;
    int            lo_at;
    int            hi_at;
    logic [DW-1:0] mid;
    logic [DW-1:0] exp_data;
    logic          exp_ovr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy      = 1'b0;
    m_tx        = 1'b1;
    m_done      = 1'b0;
    m_ovr       = 1'b0;
    m_prev_load = 1'b1;
  endtask

  task automatic model_step();
    bit rise;
    rise        = load && !m_prev_load;
    m_prev_load = load;
    m_done      = 1'b0;
    if (m_busy) begin
      if (rise) m_ovr = 1'b1;
      if (mq.size() > 0) begin
        m_tx = mq.pop_front();
      end else begin
        m_busy = 1'b0;
        m_tx   = 1'b1;
        m_done = 1'b1;
      end
    end else if (rise) begin
      mq.delete();
      for (int k = 0; k < CPB; k++) mq.push_back(1'b0);
      for (int i = 0; i < DW; i++)
        for (int k = 0; k < CPB; k++) mq.push_back(data_in[i]);
      for (int k = 0; k < CPB; k++) mq.push_back(1'b1);
      m_tx   = mq.pop_front();
      m_busy = 1'b1;
      m_ovr  = 1'b0;
    end
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    check("tx", tx, m_tx);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("overrun", overrun, m_ovr);
  endtask

  // Raise load with payload d, optionally drop/re-raise load mid-frame, decode the line.
  task automatic run_frame(input logic [DW-1:0] d, input int lo_at, input int hi_at,
                           input logic [DW-1:0] d_mid, output logic [DW-1:0] dec,
                           output int busy_cnt);
    logic smp[$];
    int   c;
    bit   seen_done;
    int   idx;
    c         = 0;
    seen_done = 1'b0;
    busy_cnt  = 0;
    data_in   = d;
    load      = 1'b1;
    while (!seen_done && c < FRAME + 20) begin
      cycle();
      c++;
      if (busy) begin
        busy_cnt++;
        smp.push_back(tx);
      end
      if (done) seen_done = 1'b1;
      if (c == lo_at) load = 1'b0;
      if (c == hi_at) begin
        load    = 1'b1;
        data_in = d_mid;
      end
    end
    check_val("done_seen", int'(seen_done), 1);
    dec = '0;
    for (int i = 0; i < DW; i++) begin
      idx = CPB * (i + 1) + CPB / 2;
      if (idx < smp.size()) dec[i] = smp[idx];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] dec;
    int            bc;
    logic [DW-1:0] rd;
    logic [DW-1:0] rm;
    int            lo;
    int            hi;

    vecs[0] = '{data: 8'hA5, lo_at: 10, hi_at: 11, mid: 8'hFF, exp_data: 8'hA5, exp_ovr: 1'b1};
    vecs[1] = '{data: 8'h3C, lo_at: 5,  hi_at: -1, mid: 8'h00, exp_data: 8'h3C, exp_ovr: 1'b0};
    vecs[2] = '{data: 8'hC3, lo_at: -1, hi_at: -1, mid: 8'h00, exp_data: 8'hC3, exp_ovr: 1'b0};
    vecs[3] = '{data: 8'h5A, lo_at: 5,  hi_at: 40, mid: 8'h77, exp_data: 8'h5A, exp_ovr: 1'b1};

    // Reset with load already high: line idle, no frame afterwards.
    reset   = 1'b1;
    load    = 1'b1;
    data_in = '0;
    model_reset();
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    repeat (3) cycle();
    reset = 1'b0;
    repeat (100) cycle();

    // Table: overrun set by mid-frame toggle, cleared by next accept, held load, stop-exit rise.
    for (int v = 0; v < 4; v++) begin
      load = 1'b0;
      cycle();
      run_frame(vecs[v].data, vecs[v].lo_at, vecs[v].hi_at, vecs[v].mid, dec, bc);
      check_val("frame_data", int'(dec), int'(vecs[v].exp_data));
      check_val("busy_len", bc, FRAME);
      repeat (10) cycle();
      check("overrun_after", overrun, vecs[v].exp_ovr);
    end

    // Asynchronous reset during bit 3 of 0x0F, with overrun set beforehand.
    load = 1'b0;
    cycle();
    data_in = 8'h0F;
    load    = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      cycle();
      if (c == 10) load = 1'b0;
      if (c == 11) load = 1'b1;
    end
    check("ovr_pre_reset", overrun, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_overrun", overrun, 1'b0);
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;
    repeat (3) cycle();
    load = 1'b0;
    cycle();
    run_frame(8'h81, 5, -1, 8'h00, dec, bc);
    check_val("post_rst_data", int'(dec), 8'h81);
    check_val("post_rst_len", bc, FRAME);

    // Back-to-back: raise load in the done cycle, start bit one cycle later.
    load = 1'b0;
    cycle();
    run_frame(8'h00, 5, -1, 8'h00, dec, bc);
    check_val("b2b_first_data", int'(dec), 8'h00);
    load    = 1'b1;
    data_in = 8'hFF;
    cycle();
    check("b2b_start_tx", tx, 1'b0);
    check("b2b_start_busy", busy, 1'b1);
    check("b2b_overrun", overrun, 1'b0);
    repeat (FRAME + 2) cycle();

    // Randomized frames with random mid-frame load activity.
    for (int r = 0; r < 20; r++) begin
      load = 1'b0;
      repeat ($urandom_range(1, 6)) cycle();
      rd = DW'($urandom);
      rm = DW'($urandom);
      lo = $urandom_range(1, FRAME);
      hi = ($urandom_range(0, 1) == 1) ? lo + int'($urandom_range(1, 5)) : -1;
      run_frame(rd, lo, hi, rm, dec, bc);
      check_val("rand_data", int'(dec), int'(rd));
      check_val("rand_len", bc, FRAME);
    end
    load = 1'b0;
    repeat (5) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
